// File: rtl/ex_div.sv
// Execute stage: combinational logic/shift unit plus a 32-iteration restoring
// divider that stalls the pipeline and writes the quotient/remainder to HI/LO.
module ex_div #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        aluop_i,
   input  logic [2:0]        alusel_i,
   input  logic [DATA_W-1:0] reg1_i,
   input  logic [DATA_W-1:0] reg2_i,
   input  logic [4:0]        wd_i,
   input  logic              wreg_i,
   input  logic              annul_i,
   output logic [4:0]        wd_o,
   output logic              wreg_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic              whilo_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o,
   output logic              stallreq_o
);

   localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
   localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
   localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
   localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
   localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
   localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
   localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
   localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;
   localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
   localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

   typedef enum logic [1:0] {S_IDLE, S_BY_ZERO, S_ON, S_END} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] divisor;
   logic [DATA_W-1:0] rem;
   logic [DATA_W-1:0] quot;
   logic              sign_a;
   logic              sign_b;
   logic              is_signed;

   logic              is_div;
   logic              op_signed;
   logic [DATA_W-1:0] logic_res;
   logic [DATA_W-1:0] shift_res;
   logic [DATA_W:0]   partial;
   logic [DATA_W:0]   diff;
   logic [DATA_W-1:0] quot_s;
   logic [DATA_W-1:0] rem_s;

   assign is_div    = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
   assign op_signed = (aluop_i == EXE_DIV_OP);

   always_comb begin
      logic_res = '0;
      shift_res = '0;
      case (aluop_i)
         EXE_AND_OP: logic_res = reg1_i & reg2_i;
         EXE_OR_OP:  logic_res = reg1_i | reg2_i;
         EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
         EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
         EXE_SLL_OP: shift_res = reg2_i << reg1_i[4:0];
         EXE_SRL_OP: shift_res = reg2_i >> reg1_i[4:0];
         EXE_SRA_OP: shift_res = $signed(reg2_i) >>> reg1_i[4:0];
         default: ;
      endcase
   end

   // One restoring step: shift {rem,quot} left, trial-subtract the divisor.
   assign partial = {rem, quot[DATA_W-1]};
   assign diff    = partial - {1'b0, divisor};

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         divisor   <= '0;
         rem       <= '0;
         quot      <= '0;
         sign_a    <= 1'b0;
         sign_b    <= 1'b0;
         is_signed <= 1'b0;
      end else if (annul_i) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (is_div) begin
                  is_signed <= op_signed;
                  sign_a    <= op_signed & reg1_i[DATA_W-1];
                  sign_b    <= op_signed & reg2_i[DATA_W-1];
                  quot      <= (op_signed && reg1_i[DATA_W-1]) ? -reg1_i : reg1_i;
                  divisor   <= (op_signed && reg2_i[DATA_W-1]) ? -reg2_i : reg2_i;
                  rem       <= '0;
                  cnt       <= '0;
                  state     <= (reg2_i == '0) ? S_BY_ZERO : S_ON;
               end
            end
            S_BY_ZERO: begin
               rem   <= '0;
               quot  <= '0;
               state <= S_END;
            end
            S_ON: begin
               if (!diff[DATA_W]) begin
                  rem  <= diff[DATA_W-1:0];
                  quot <= {quot[DATA_W-2:0], 1'b1};
               end else begin
                  rem  <= partial[DATA_W-1:0];
                  quot <= {quot[DATA_W-2:0], 1'b0};
               end
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(DATA_W - 1)) state <= S_END;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Magnitudes are unsigned; restore signs only for DIV at write-back.
   assign quot_s = (is_signed && (sign_a ^ sign_b)) ? -quot : quot;
   assign rem_s  = (is_signed && sign_a) ? -rem : rem;

   always_comb begin
      wd_o       = '0;
      wreg_o     = 1'b0;
      wdata_o    = '0;
      whilo_o    = 1'b0;
      hi_o       = '0;
      lo_o       = '0;
      stallreq_o = 1'b0;
      if (!rst) begin
         wd_o   = wd_i;
         wreg_o = wreg_i;
         if (alusel_i == EXE_RES_LOGIC)      wdata_o = logic_res;
         else if (alusel_i == EXE_RES_SHIFT) wdata_o = shift_res;
         if (!annul_i) begin
            case (state)
               S_IDLE:    stallreq_o = is_div;
               S_BY_ZERO: stallreq_o = 1'b1;
               S_ON:      stallreq_o = 1'b1;
               default: begin
                  whilo_o = 1'b1;
                  hi_o    = rem_s;
                  lo_o    = quot_s;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ex_div.sv
// Bench for ex_div: directed and random logic/shift/divide stimulus checked
// against an arithmetic reference model.
module tb_ex_div;

   localparam logic [7:0] OP_NOP  = 8'b0000_0000;
   localparam logic [7:0] OP_AND  = 8'b0010_0100;
   localparam logic [7:0] OP_OR   = 8'b0010_0101;
   localparam logic [7:0] OP_XOR  = 8'b0010_0110;
   localparam logic [7:0] OP_NOR  = 8'b0010_0111;
   localparam logic [7:0] OP_SLL  = 8'b0111_1100;
   localparam logic [7:0] OP_SRL  = 8'b0000_0010;
   localparam logic [7:0] OP_SRA  = 8'b0000_0011;
   localparam logic [7:0] OP_DIV  = 8'b0001_1010;
   localparam logic [7:0] OP_DIVU = 8'b0001_1011;
   localparam logic [2:0] RES_NOP   = 3'b000;
   localparam logic [2:0] RES_LOGIC = 3'b001;
   localparam logic [2:0] RES_SHIFT = 3'b010;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  aluop;
   logic [2:0]  alusel;
   logic [31:0] reg1, reg2;
   logic [4:0]  wd;
   logic        wreg, annul;
   logic [4:0]  wd_out;
   logic        wreg_out;
   logic [31:0] wdata;
   logic        whilo;
   logic [31:0] hi, lo;
   logic        stallreq;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];

   ex_div dut (
      .clk(clk), .rst(rst), .aluop_i(aluop), .alusel_i(alusel),
      .reg1_i(reg1), .reg2_i(reg2), .wd_i(wd), .wreg_i(wreg), .annul_i(annul),
      .wd_o(wd_out), .wreg_o(wreg_out), .wdata_o(wdata), .whilo_o(whilo),
      .hi_o(hi), .lo_o(lo), .stallreq_o(stallreq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_alu(input logic [7:0] op, input logic [2:0] sel,
                                             input logic [31:0] a, input logic [31:0] b);
      int sh;
      sh = int'(a[4:0]);
      if (sel == RES_LOGIC) begin
         if (op == OP_AND) return a & b;
         if (op == OP_OR)  return a | b;
         if (op == OP_XOR) return a ^ b;
         if (op == OP_NOR) return ~(a | b);
         return 32'h0;
      end
      if (sel == RES_SHIFT) begin
         if (op == OP_SLL) return b << sh;
         if (op == OP_SRL) return b >> sh;
         if (op == OP_SRA) return 32'(longint'($signed(b)) >>> sh);
         return 32'h0;
      end
      return 32'h0;
   endfunction

   // Returns {hi, lo}: truncating division, remainder follows dividend sign.
   function automatic logic [63:0] model_div(input logic sgn, input logic [31:0] a,
                                             input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'h0) return 64'h0;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'h0, a});
         sb = longint'({32'h0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic idle_inputs();
      aluop = OP_NOP; alusel = RES_NOP; reg1 = '0; reg2 = '0;
      wd = '0; wreg = 1'b0; annul = 1'b0;
   endtask

   task automatic apply_alu(input string tag, input logic [7:0] op, input logic [2:0] sel,
                            input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      aluop = op; alusel = sel; reg1 = a; reg2 = b;
      wd = 5'($urandom_range(0, 31)); wreg = 1'($urandom_range(0, 1));
      @(negedge clk);
      check({tag, ".wdata"}, wdata, model_alu(op, sel, a, b));
      check({tag, ".wd"}, 32'(wd_out), 32'(wd));
      check({tag, ".wreg"}, 32'(wreg_out), 32'(wreg));
      check({tag, ".stall"}, 32'(stallreq), 32'h0);
   endtask

   // Issue a divide and follow it to the HI/LO write; inputs are scrambled
   // after the first stalled cycle to show the latched operands are used.
   task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b);
      logic [63:0] r;
      int stall_cnt, bad, end_cyc;
      r = model_div(sgn, a, b);
      exp_q.push_back(r[31:0]);
      exp_q.push_back(r[63:32]);
      @(posedge clk); #1;
      aluop = sgn ? OP_DIV : OP_DIVU; alusel = RES_NOP; reg1 = a; reg2 = b;
      wd = 5'd0; wreg = 1'b0;
      stall_cnt = 0; bad = 0; end_cyc = -1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         if (whilo) begin
            end_cyc = cyc;
            break;
         end
         if (stallreq) stall_cnt++;
         if (wdata != 32'h0 || hi != 32'h0 || lo != 32'h0) bad++;
         if (cyc == 1) begin
            reg1 = $urandom; reg2 = $urandom;
         end
      end
      check({tag, ".end_cycle"}, 32'(end_cyc), (b == 0) ? 32'd2 : 32'd33);
      check({tag, ".stall_cycles"}, 32'(stall_cnt), (b == 0) ? 32'd2 : 32'd33);
      check({tag, ".quiet_while_busy"}, 32'(bad), 32'd0);
      check({tag, ".end_stall"}, 32'(stallreq), 32'h0);
      check({tag, ".lo"}, lo, exp_q.pop_front());
      check({tag, ".hi"}, hi, exp_q.pop_front());
      aluop = OP_NOP;
      @(negedge clk);
      check({tag, ".whilo_after"}, 32'(whilo), 32'h0);
      check({tag, ".stall_after"}, 32'(stallreq), 32'h0);
   endtask

   // Abort a DIVU in ON cycle 10 either with annul_i or rst.
   task automatic abort_div(input string tag, input logic use_rst);
      int pulses;
      @(posedge clk); #1;
      aluop = OP_DIVU; alusel = RES_NOP; reg1 = 32'd1000; reg2 = 32'd3;
      wd = 5'd9; wreg = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      aluop = OP_NOP;
      if (use_rst) rst = 1'b1; else annul = 1'b1;
      @(negedge clk);
      check({tag, ".stall_now"}, 32'(stallreq), 32'h0);
      check({tag, ".whilo_now"}, 32'(whilo), 32'h0);
      if (use_rst) begin
         check({tag, ".wd_zero"}, 32'(wd_out), 32'h0);
         check({tag, ".wreg_zero"}, 32'(wreg_out), 32'h0);
      end
      @(posedge clk); #1;
      rst = 1'b0; annul = 1'b0;
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (whilo || stallreq) pulses++;
      end
      check({tag, ".no_write_later"}, 32'(pulses), 32'h0);
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      aluop = OP_OR; alusel = RES_LOGIC; reg1 = 32'hFFFF_FFFF; reg2 = 32'h1234_5678;
      wd = 5'd7; wreg = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset.wdata", wdata, 32'h0);
      check("reset.wd", 32'(wd_out), 32'h0);
      check("reset.wreg", 32'(wreg_out), 32'h0);
      check("reset.whilo", 32'(whilo), 32'h0);
      check("reset.stall", 32'(stallreq), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      idle_inputs();

      @(posedge clk); #1;
      aluop = OP_OR; alusel = RES_LOGIC; reg1 = 32'h1100_FF00; reg2 = 32'h0000_F0F0;
      wd = 5'd5; wreg = 1'b1;
      @(negedge clk);
      check("or.wdata", wdata, 32'h1100_FFF0);
      check("or.wd", 32'(wd_out), 32'd5);
      check("or.wreg", 32'(wreg_out), 32'd1);
      check("or.stall", 32'(stallreq), 32'h0);

      apply_alu("sra", OP_SRA, RES_SHIFT, 32'd4, 32'h8000_0010);
      check("sra.literal", wdata, 32'hF800_0001);
      apply_alu("srl", OP_SRL, RES_SHIFT, 32'd4, 32'h8000_0010);
      check("srl.literal", wdata, 32'h0800_0001);

      for (int i = 0; i < 40; i++) begin
         logic [7:0] ops[7];
         logic [2:0] sels[3];
         ops = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA};
         sels = '{RES_LOGIC, RES_SHIFT, RES_NOP};
         apply_alu("rnd_alu", ops[$urandom_range(0, 6)], sels[$urandom_range(0, 2)],
                   $urandom, $urandom);
      end

      run_div("divu_100_7", 1'b0, 32'd100, 32'd7);
      check("divu_100_7.lo_literal", 32'd14, model_div(1'b0, 32'd100, 32'd7) >> 0);
      run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
      run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      run_div("div_by0", 1'b1, 32'h1234_5678, 32'h0);
      run_div("divu_by0", 1'b0, 32'hFFFF_FFFF, 32'h0);
      run_div("divu_max", 1'b0, 32'hFFFF_FFFF, 32'h1);

      abort_div("annul", 1'b0);
      abort_div("rst_abort", 1'b1);
      run_div("after_abort", 1'b0, 32'd1000, 32'd3);

      for (int i = 0; i < 12; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom >> $urandom_range(0, 31);
         run_div("rnd_div", 1'($urandom_range(0, 1)), a, b);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Execute stage placed directly downstream of the decode stage. Consumes aluop/alusel/operands/destination from the ID/EX pipeline register.
- Logic and shift results are produced combinationally in the same cycle.
- DIV/DIVU run on an embedded 32-iteration restoring divider. It holds the pipeline through stallreq_o and delivers the quotient/remainder pair to the HI/LO write port.

Parameters:
- DATA_W, 32, operand/result width (RegBus)
- CNT_W, 6, iteration counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- aluop_i  in  8  operation code: EXE_{AND,OR,XOR,NOR,SLL,SRL,SRA,NOP,DIV,DIVU}_OP
- alusel_i  in  3  result class: EXE_RES_{LOGIC,SHIFT,NOP}
- reg1_i  in  32  operand 1; rs value, or shamt in [4:0] for sll/srl/sra
- reg2_i  in  32  operand 2; rt value or immediate
- wd_i  in  5  GPR destination
- wreg_i  in  1  GPR write enable
- annul_i  in  1  flush; aborts any divide in progress
- wd_o  out  5  GPR destination, = wd_i
- wreg_o  out  1  GPR write enable, = wreg_i
- wdata_o  out  32  GPR write data
- whilo_o  out  1  HI/LO write enable
- hi_o  out  32  HI write data (remainder)
- lo_o  out  32  LO write data (quotient)
- stallreq_o  out  1  request to stall PC/IF/ID/EX

Behaviour:

Reset:
- While rst=1: all outputs are 0.
- At the next edge: state=IDLE, counter=0, dividend/divisor/result registers cleared.

Logic and shift (combinational):
- AND/OR/XOR/NOR: reg1_i op reg2_i.
- SLL: reg2_i << reg1_i[4:0].
- SRL: logical reg2_i >> reg1_i[4:0].
- SRA: arithmetic reg2_i >>> reg1_i[4:0]; sign is reg2_i[31].
- wdata_o selects by alusel_i: LOGIC → logic result, SHIFT → shift result, anything else → 0.

Divide FSM states: IDLE, BY_ZERO, ON, END.
- IDLE:
  - aluop_i∈{DIV,DIVU} with annul_i=0 → stallreq_o=1.
  - If reg2_i==0: next state BY_ZERO.
  - Otherwise: latch the dividend/divisor as magnitudes (DIV takes two's-complement absolute values; DIVU takes raw values), latch both signs, clear counter, next state ON.
- BY_ZERO: stallreq_o=1; result={0,0}; next state END.
- ON:
  - stallreq_o=1.
  - Each cycle performs one restoring step: shift {rem,quot} left by 1; if rem ≥ divisor, subtract and set the quot LSB.
  - counter increments each cycle. After step 32 (counter==31), next state END.
- END:
  - stallreq_o=0, whilo_o=1.
  - For DIV, apply signs: quotient negated if sign(a)≠sign(b); remainder takes sign(a).
  - lo_o=quotient, hi_o=remainder.
  - Next state IDLE unconditionally. The pipeline advances on this edge.
- whilo_o, hi_o and lo_o are 0 in all states other than END.

Latency:
- Issue in cycle 0.
- Nonzero divisor: 32 ON cycles, END in cycle 33, total 34 cycles, 33 stall cycles.
- Zero divisor: END in cycle 2.

Signed overflow:
- 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps naturally through abs/negate).

annul_i:
- Forces next state IDLE from any state, discarding the partial result.
- While annul_i=1: stallreq_o=0 and whilo_o=0.

Divide side effects:
- wreg_i is passed through unchanged; decode drives it to 0 for divides.
- wdata_o=0 during a divide.

Mid-operation changes:
- rst during ON → IDLE at the next edge; no HI/LO write.
- Changes on reg1_i/reg2_i during ON are ignored; the latched operands are used.

Test Plan:
- alusel=LOGIC, aluop=OR, reg1=0x1100FF00, reg2=0x0000F0F0, wd=5, wreg=1 → same-cycle wdata_o=0x1100FFF0, wd_o=5, wreg_o=1, stallreq_o=0.
- alusel=SHIFT, aluop=SRA, reg1=4, reg2=0x80000010 → wdata_o=0xF8000001. Then aluop=SRL → wdata_o=0x08000001.
- DIVU reg1=100, reg2=7 held under stall → stallreq_o=1 for 33 cycles; in cycle 33 whilo_o=1, lo_o=14, hi_o=2; whilo_o=0 the next cycle.
- DIV reg1=0xFFFFFFF9 (-7), reg2=2 → lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF at END. Repeat with 0x80000000 / 0xFFFFFFFF → lo_o=0x80000000, hi_o=0.
- DIV with reg2=0 → stallreq_o high for 2 cycles; in cycle 2 whilo_o=1, hi_o=lo_o=0.
- DIVU started, annul_i=1 in ON cycle 10 → stallreq_o=0 immediately, FSM IDLE next edge, no whilo_o pulse. Repeat with rst=1 in cycle 10 → all outputs 0, IDLE next edge.
